// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: job sequencer for a tap-programmable LFSR step unit, streaming states over valid/ready
module lfsr_seq_ctrl #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [W-1:0]     cfg_taps_i,
   input  logic [W-1:0]     cfg_seed_i,
   input  logic [CNT_W-1:0] cfg_count_i,
   input  logic             abort_i,
   output logic [W-1:0]     lfsr_state_o,
   input  logic [W-1:0]     lfsr_next_i,
   output logic [W-1:0]     lfsr_tap_in_o,
   output logic             lfsr_tap_en_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W-1:0]     out_data_o,
   output logic             out_last_o,
   output logic             busy_o,
   output logic             err_seed_o
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} st_t;
   st_t              st_q;
   logic [W-1:0]     state_q, taps_q;
   logic [CNT_W-1:0] cnt_q;
   logic             bnd_q, ready_q, tap_en_q, valid_q, last_q, busy_q, err_q;
   logic             hs;
   assign hs = valid_q & out_ready_i;
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         st_q     <= IDLE;
         state_q  <= '0;
         taps_q   <= '0;
         cnt_q    <= '0;
         bnd_q    <= 1'b0;
         ready_q  <= 1'b1;
         tap_en_q <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q    <= 1'b0;
         tap_en_q <= 1'b0;
         case (st_q)
            IDLE: if (cfg_valid_i) begin
               if (cfg_seed_i == '0) err_q <= 1'b1;
               else begin
                  st_q     <= LOAD;
                  taps_q   <= cfg_taps_i;
                  state_q  <= cfg_seed_i;
                  cnt_q    <= cfg_count_i;
                  bnd_q    <= cfg_count_i != '0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  tap_en_q <= 1'b1;
               end
            end
            LOAD: if (abort_i) begin
               st_q    <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end else begin
               st_q    <= RUN;
               valid_q <= 1'b1;
               last_q  <= bnd_q && cnt_q == CNT_W'(1);
            end
            RUN: begin
               if (hs) begin
                  state_q <= lfsr_next_i;
                  if (bnd_q) cnt_q <= cnt_q - CNT_W'(1);
                  last_q  <= bnd_q && cnt_q == CNT_W'(2);
               end
               // a beat handshaken alongside abort still counts as delivered
               if (abort_i || (hs && last_q)) begin
                  st_q    <= IDLE;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end
   assign cfg_ready_o   = ready_q;
   assign lfsr_state_o  = state_q;
   assign lfsr_tap_in_o = taps_q;
   assign lfsr_tap_en_o = tap_en_q;
   assign out_valid_o   = valid_q;
   assign out_data_o    = lfsr_next_i;
   assign out_last_o    = last_q;
   assign busy_o        = busy_q;
   assign err_seed_o    = err_q;
endmodule
